// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition unit.
package cond_pkg;

   // ARM condition field encodings; NV (1111) is treated as never.
   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_t;

   // NZCV bit positions within a flag vector.
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // Stall FSM: RUN issues normally, HOLD re-evaluates the held instruction.
   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } cu_state_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV flag vector.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_true
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Decode the condition field into a pass/fail decision.
   always_comb begin
      cond_true = 1'b0;
      case (cond_t'(cond))
         EQ:      cond_true = z;
         NE:      cond_true = ~z;
         CS:      cond_true = c;
         CC:      cond_true = ~c;
         MI:      cond_true = n;
         PL:      cond_true = ~n;
         VS:      cond_true = v;
         VC:      cond_true = ~v;
         HI:      cond_true = c & ~z;
         LS:      cond_true = ~c | z;
         GE:      cond_true = (n == v);
         LT:      cond_true = (n != v);
         GT:      cond_true = ~z & (n == v);
         LE:      cond_true = z | (n != v);
         AL:      cond_true = 1'b1;
         NV:      cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: gates side effects on the condition field and
// drives the registered CPSR flag write. Define COND_BYPASS_EN to forward the
// in-flight flag write instead of stalling for one cycle.
module cond_unit
   import cond_pkg::*;
#(
   parameter int unsigned bus = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid,
   input  logic [3:0]     cond,
   input  logic           set_flags,
   input  logic [bus-1:0] alu_flags,
   input  logic [bus-1:0] cpsr_flags,
   input  logic           reg_write,
   input  logic           mem_write,
   input  logic           pc_src,
   output logic           reg_write_o,
   output logic           mem_write_o,
   output logic           pc_src_o,
   output logic           cond_ex,
   output logic           stall,
   output logic           cpsr_we,
   output logic [bus-1:0] cpsr_datain
);

   logic [bus-1:0] eff_flags;
   logic           cond_true;
   logic           pass;

`ifdef COND_BYPASS_EN
   // A write asserted this cycle is not yet visible on cpsr_flags; forward it.
   assign eff_flags = cpsr_we ? cpsr_datain : cpsr_flags;
   assign stall     = 1'b0;
`else
   cu_state_t state_q, state_d;

   assign eff_flags = cpsr_flags;

   // Stall FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Stall a flag-dependent instruction while the previous write is in flight.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         RUN: begin
            stall = valid & cpsr_we & (cond != AL);
            if (stall) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end
`endif

   cond_check u_cond_check (
      .cond      (cond),
      .flags     (eff_flags),
      .cond_true (cond_true)
   );

   // Gate the architectural side effects on the condition result.
   always_comb begin
      pass        = valid & cond_true & ~stall;
      cond_ex     = pass;
      reg_write_o = pass & reg_write;
      mem_write_o = pass & mem_write;
      pc_src_o    = pass & pc_src;
   end

   // Flag write register feeding the CPSR; the latest passing setter wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpsr_we     <= 1'b0;
         cpsr_datain <= '0;
      end else begin
         cpsr_we <= pass & set_flags;
         if (pass & set_flags) begin
            cpsr_datain <= alu_flags;
         end
      end
   end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage condition unit of the ARMv4 core, sitting directly upstream of the CPSR flag register. Each cycle it evaluates the instruction's 4-bit condition field against the current NZCV flags and gates the instruction's architectural side effects (register write, memory write, PC redirect). When the instruction passes and has its S bit set, it produces the registered `cpsr_we`/`cpsr_datain` pair that drives the CPSR. It also resolves the two-cycle flag visibility latency that this registered write path creates, by bypass or by stall.

## Interface
Parameters:
- `bus`, default 4: flag width, NZCV. Only 4 is supported.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `valid`, input, 1: an instruction is present in execute this cycle.
- `cond`, input, 4: instruction condition field [31:28].
- `set_flags`, input, 1: S bit; the instruction requests a flag update.
- `alu_flags`, input, `bus`: NZCV produced by the ALU for this instruction.
- `cpsr_flags`, input, `bus`: the CPSR `dataout`.
- `reg_write`, `mem_write`, `pc_src`, input, 1 each: ungated control requests from decode.
- `reg_write_o`, `mem_write_o`, `pc_src_o`, output, 1 each: gated controls.
- `cond_ex`, output, 1: the condition passed for a valid, non-stalled instruction.
- `stall`, output, 1: hold execute and upstream stages this cycle. Constant 0 when `COND_BYPASS_EN` is defined.
- `cpsr_we`, output, 1: registered; drives CPSR `CPSR_WE`.
- `cpsr_datain`, output, `bus`: registered; drives CPSR `datain`.

## Operation
- Flag bit order is N=3, Z=2, C=1, V=0 in `alu_flags`, `cpsr_flags` and `cpsr_datain`.
- Condition evaluation is combinational against `eff_flags`:
  - EQ: Z.
  - NE: !Z.
  - CS: C.
  - CC: !C.
  - MI: N.
  - PL: !N.
  - VS: V.
  - VC: !V.
  - HI: C&!Z.
  - LS: !C|Z.
  - GE: N==V.
  - LT: N!=V.
  - GT: !Z&(N==V).
  - LE: Z|(N!=V).
  - AL (1110): 1.
  - 1111: treated as never, result 0.
- `pass = valid & cond_true & ~stall`.
- `reg_write_o = pass & reg_write`. `mem_write_o` and `pc_src_o` are gated the same way. `cond_ex = pass`.
- Flag write register, updated at each rising edge:
  - `cpsr_we <= pass & set_flags`.
  - `cpsr_datain <= alu_flags` when `pass & set_flags`; otherwise it holds its value.
- Write path to visibility: a flag write from the instruction in cycle N is asserted to the CPSR during N+1, latched by the CPSR at the falling edge in N+1, and visible on `cpsr_flags` from N+2. The instruction in N+1 therefore sees stale `cpsr_flags`.
- `eff_flags` depends on configuration; see Configuration.
- Stall FSM, states RUN and HOLD (compiled in only without `COND_BYPASS_EN`):
  - RUN: `stall = valid & cpsr_we & (cond != 1110)`. If `stall` is 1, go to HOLD.
  - HOLD: `stall = 0`. The held instruction evaluates against the now-updated `cpsr_flags`. Go to RUN.
  - AL-conditioned instructions never stall.
  - During a stall, upstream holds `valid`/`cond`/controls stable, and all gated outputs are 0.
- Reset: `cpsr_we`=0, `cpsr_datain`=0000, FSM=RUN. `stall` and the gated outputs follow combinationally. Asserting reset during HOLD or with a write in flight drops the pending write and returns the FSM to RUN.

## Timing
- Condition decision and gated controls: 0-cycle latency, same cycle as `valid`.
- `cpsr_we`/`cpsr_datain`: 1-cycle latency after the instruction.
- Flags are architecturally visible on `cpsr_flags` 2 cycles after the setting instruction.
- Back-to-back flag setters: each cycle's write overwrites the previous one. The latest setter always wins, in both configurations.
- Stall cost without bypass: exactly 1 cycle per conditional instruction that immediately follows a passing flag setter.
- `valid`=0: no side effects and no flag write. `cpsr_we` deasserts on the next edge.

## Configuration
- `COND_BYPASS_EN` defined:
  - `eff_flags = cpsr_we ? cpsr_datain : cpsr_flags`.
  - `stall` is tied to 0 and the FSM is removed.
- `COND_BYPASS_EN` undefined:
  - `eff_flags = cpsr_flags`.
  - The RUN/HOLD FSM provides the 1-cycle stall.
- Both configurations are architecturally identical. They differ only in cycle count.

## Structure
- `cond_pkg`:
  - enum `cond_t` (EQ..AL, NV).
  - flag index constants `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V`.
  - FSM state enum `cu_state_t` {RUN, HOLD}.
- Sub-module `cond_check`: purely combinational; inputs `cond` and `flags`, output `cond_true`. Instantiated once.
- The flag-write register and the FSM live in the top module.

## Test plan
1. Reset held 2 cycles, then released:
   - `cpsr_we`=0, `cpsr_datain`=0000.
   - `stall`=0, all gated outputs 0.
2. SUBS with `alu_flags`=0100 and AL, then BEQ (`cond`=0000, `pc_src`=1) next cycle:
   - bypass build: `pc_src_o`=1 with no stall.
   - no-bypass build: `stall`=1 for one cycle, then `pc_src_o`=1.
3. ADDS (`alu_flags`=1001), then ADDS (`alu_flags`=0010), then BCS 2 cycles later:
   - `cpsr_datain` takes 1001, then 0010.
   - The branch is taken (C=1).
4. Conditional ADDNE with `set_flags` while Z=1:
   - `reg_write_o`=0.
   - `cpsr_we` stays 0 on the next edge.
   - CPSR is unchanged.
5. `cond`=1111 with all requests high:
   - all gated outputs 0, `cpsr_we`=0.
6. No-bypass build, reset asserted during HOLD with `cpsr_we`=1:
   - next cycle FSM=RUN, `cpsr_we`=0, `stall`=0.
